cpu_mc: RTL and testbench
=========================

Name: cpu_mc

Overview:
- Parametrised multi-cycle successor to the 8-bit single-cycle CPU core.
- Keeps the existing 32-bit instruction format and opcode map. Adds word-width and register-count parameters, an internal FSM, and stalling handshakes to instruction and data memory (busywait).
- Adds load/store instructions.
- Sits between the instruction cache/memory and the data cache/memory at top level.

Parameters:
- DATA_W, 8, datapath, register and data-address width (8..32).
- REG_ADDR_W, 3, register index width; register file has 2**REG_ADDR_W entries (max 8, field is 8 bits).
- PC_W, 32, program counter width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- PC  out  PC_W  fetch address.
- INSTRUCTION  in  32  instruction word for PC.
- IBUSYWAIT  in  1  high = instruction not yet valid.
- READ  out  1  data-memory read request.
- WRITE  out  1  data-memory write request.
- ADDRESS  out  DATA_W  data-memory address.
- WRITEDATA  out  DATA_W  store data.
- READDATA  in  DATA_W  load data.
- DBUSYWAIT  in  1  high = data access not complete.
- ILLEGAL  out  1  one-cycle pulse in WB for an unsupported opcode.

Behaviour:
- Fields: [31:24] opcode, [23:16] rd/offset, [15:8] rt, [7:0] rs/imm. Register fields use the low REG_ADDR_W bits.
- Opcodes:
  - 00 loadi, 01 mov, 02 add, 03 sub, 04 and, 05 or
  - 06 j, 07 beq, 08 lwd, 09 lwi, 0A swd, 0B swi, 0C bne
  - 0D mult, 0E sll, 0F srl, 10 sra
  - all others illegal.
- Reset (async, RESET=0):
  - PC=0, all registers=0, READ=WRITE=0, ADDRESS=WRITEDATA=0, ILLEGAL=0, state=FETCH.
  - A reset asserted mid-access drops READ/WRITE immediately; the pending store is abandoned.
- FSM states: FETCH, EXEC, MEM, WB.
  - FETCH: PC held. On the first edge with IBUSYWAIT=0, INSTRUCTION is latched into IR and the state goes to EXEC.
  - EXEC (1 cycle): read rt/rs, compute the ALU result and branch decision. Loads/stores go to MEM; everything else goes to WB.
  - MEM: READ (lwd/lwi) or WRITE (swd/swi) is registered high on entry, with ADDRESS/WRITEDATA stable. Memory must raise DBUSYWAIT combinationally in the same cycle if stalling. On the first edge with DBUSYWAIT=0: READDATA is captured (loads), READ/WRITE are cleared, and the state goes to WB.
  - WB (1 cycle): register write (if any), PC update, then back to FETCH.
- Latency with zero-wait memories: ALU/branch instructions take 3 cycles; loads/stores take 4.
- Arithmetic and widths:
  - loadi imm is sign-extended to DATA_W.
  - add/sub/mult results are truncated to DATA_W (mult keeps the low DATA_W bits); sub = rt + two's complement of rs.
  - Shift amount is imm[7:0]. If amount >= DATA_W: sll/srl give 0, sra gives all copies of the sign bit.
  - lwi/swi address is imm zero-extended.
  - lwd rd,rs: ADDRESS = reg[rs].
  - swd rt,rs: ADDRESS = reg[rs], WRITEDATA = reg[rt].
  - swi rt,imm: ADDRESS = imm, WRITEDATA = reg[rt].
- PC update:
  - Default next PC = PC+4.
  - j, beq taken (rt==rs), bne taken (rt!=rs): PC+4 + (sext(offset)<<2), modulo 2**PC_W (wraps).
- Stores, branches, jumps and illegal opcodes write no register.
- Illegal opcode: executes as a NOP (PC+4) and pulses ILLEGAL in WB.
- A write to rd followed by a read of the same register in the next instruction sees the new value; there is no hazard, because WB completes before the next FETCH.

Optional Feature:
- Macro: CPU_MC_MULT_EN.
- Defined: opcode 0D performs the truncated multiply.
- Undefined: no multiplier is synthesised; 0D is illegal (NOP, ILLEGAL pulse, no register write).

Test Plan:
- Reset and loadi:
  - RESET low mid-FETCH → PC=0, READ=WRITE=0.
  - Release, zero-wait memories, loadi r1,0xF0 with DATA_W=16 → r1=0xFFF0 after 3 cycles, PC=4.
- Arithmetic:
  - loadi r2,5; loadi r3,7; sub r4,r2,r3 → r4=0xFE (DATA_W=8).
  - add r5,r4,r3 → 0x05.
- Branch:
  - beq offset=0xFE with r2==r2 at PC=8 → PC=4.
  - bne with equal operands → PC=12.
- Load with stall:
  - lwi r1,0x20, DBUSYWAIT high for 3 cycles, READDATA=0xA5.
  - READ held 4 cycles, ADDRESS=0x20, r1=0xA5, total 7 cycles.
- Store then fetch stall:
  - swd r1,r2 (r2=0x10) → WRITE=1, ADDRESS=0x10, WRITEDATA=0xA5 until DBUSYWAIT low.
  - IBUSYWAIT high 2 cycles on the next fetch → PC stable, no state change.
- Shift, mult, illegal:
  - sra of 0x80 by 9 → 0xFF; srl of 0x80 by 9 → 0x00.
  - mult 0x10*0x11 → 0x10 (with CPU_MC_MULT_EN), else ILLEGAL pulse.
  - opcode 0x3F → ILLEGAL=1 for one cycle, PC+4.

Source files
------------

// File: rtl/cpu_mc.sv
// cpu_mc: parametrised multi-cycle CPU core (FETCH/EXEC/MEM/WB) with busywait handshakes to instruction and data memory.
// Optional feature: define CPU_MC_MULT_EN to implement opcode 0x0D (truncated multiply); otherwise 0x0D is illegal.
module cpu_mc #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned PC_W       = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic [PC_W-1:0]   PC,
    input  logic [31:0]       INSTRUCTION,
    input  logic              IBUSYWAIT,
    output logic              READ,
    output logic              WRITE,
    output logic [DATA_W-1:0] ADDRESS,
    output logic [DATA_W-1:0] WRITEDATA,
    input  logic [DATA_W-1:0] READDATA,
    input  logic              DBUSYWAIT,
    output logic              ILLEGAL
);
    localparam int unsigned NREGS = 2**REG_ADDR_W;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_LWD   = 8'h08;
    localparam logic [7:0] OP_LWI   = 8'h09;
    localparam logic [7:0] OP_SWD   = 8'h0A;
    localparam logic [7:0] OP_SWI   = 8'h0B;
    localparam logic [7:0] OP_BNE   = 8'h0C;
`ifdef CPU_MC_MULT_EN
    localparam logic [7:0] OP_MULT  = 8'h0D;
`endif
    localparam logic [7:0] OP_SLL   = 8'h0E;
    localparam logic [7:0] OP_SRL   = 8'h0F;
    localparam logic [7:0] OP_SRA   = 8'h10;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_WB} state_e;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d, npc_q, npc_d;
    logic [31:0]         ir_q, ir_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                wen_q, wen_d;
    logic                read_q, read_d, write_q, write_d;
    logic [DATA_W-1:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic                illegal_q, illegal_d;
    logic                rf_we;
    logic [DATA_W-1:0]   regs_q [NREGS];

    logic [7:0]            opcode, imm;
    logic [REG_ADDR_W-1:0] rd_idx, rt_idx, rs_idx;
    logic [DATA_W-1:0]     rt_val, rs_val, imm_sx, imm_zx, sra_val;
    logic                  shift_big;
    logic [PC_W-1:0]       pc_plus4, br_tgt;
    logic                  unused_ir;

    assign opcode    = ir_q[31:24];
    assign imm       = ir_q[7:0];
    assign rd_idx    = ir_q[16 +: REG_ADDR_W];
    assign rt_idx    = ir_q[8 +: REG_ADDR_W];
    assign rs_idx    = ir_q[0 +: REG_ADDR_W];
    assign rt_val    = regs_q[rt_idx];
    assign rs_val    = regs_q[rs_idx];
    assign imm_sx    = DATA_W'($signed(imm));
    assign imm_zx    = DATA_W'(imm);
    assign shift_big = (32'(imm) >= DATA_W);
    assign sra_val   = DATA_W'($signed(rt_val) >>> imm);
    assign pc_plus4  = pc_q + PC_W'(4);
    assign br_tgt    = pc_plus4 + (PC_W'($signed(ir_q[23:16])) << 2);
    assign unused_ir = ^ir_q[15:8];

    // Instruction decode and ALU, evaluated from IR and the register file during EXEC
    logic [DATA_W-1:0] alu_c, maddr_c;
    logic              wen_c, is_load_c, is_store_c, illegal_c, take_c;

    always_comb begin
        alu_c      = '0;
        maddr_c    = rs_val;
        wen_c      = 1'b0;
        is_load_c  = 1'b0;
        is_store_c = 1'b0;
        illegal_c  = 1'b0;
        take_c     = 1'b0;
        case (opcode)
            OP_LOADI: begin alu_c = imm_sx;            wen_c = 1'b1; end
            OP_MOV:   begin alu_c = rs_val;            wen_c = 1'b1; end
            OP_ADD:   begin alu_c = rt_val + rs_val;   wen_c = 1'b1; end
            OP_SUB:   begin alu_c = rt_val + (~rs_val + DATA_W'(1)); wen_c = 1'b1; end
            OP_AND:   begin alu_c = rt_val & rs_val;   wen_c = 1'b1; end
            OP_OR:    begin alu_c = rt_val | rs_val;   wen_c = 1'b1; end
            OP_J:     take_c = 1'b1;
            OP_BEQ:   take_c = (rt_val == rs_val);
            OP_BNE:   take_c = (rt_val != rs_val);
            OP_LWD:   begin is_load_c = 1'b1;  wen_c = 1'b1; end
            OP_LWI:   begin is_load_c = 1'b1;  wen_c = 1'b1; maddr_c = imm_zx; end
            OP_SWD:   is_store_c = 1'b1;
            OP_SWI:   begin is_store_c = 1'b1; maddr_c = imm_zx; end
`ifdef CPU_MC_MULT_EN
            OP_MULT:  begin alu_c = rt_val * rs_val;   wen_c = 1'b1; end
`endif
            OP_SLL:   begin alu_c = shift_big ? '0 : (rt_val << imm); wen_c = 1'b1; end
            OP_SRL:   begin alu_c = shift_big ? '0 : (rt_val >> imm); wen_c = 1'b1; end
            OP_SRA:   begin alu_c = shift_big ? {DATA_W{rt_val[DATA_W-1]}} : sra_val; wen_c = 1'b1; end
            default:  illegal_c = 1'b1;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        npc_d     = npc_q;
        ir_d      = ir_q;
        res_d     = res_q;
        wen_d     = wen_q;
        read_d    = read_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        illegal_d = 1'b0;
        rf_we     = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (!IBUSYWAIT) begin
                    ir_d    = INSTRUCTION;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_d = alu_c;
                wen_d = wen_c;
                npc_d = take_c ? br_tgt : pc_plus4;
                if (is_load_c || is_store_c) begin
                    read_d  = is_load_c;
                    write_d = is_store_c;
                    addr_d  = maddr_c;
                    if (is_store_c) wdata_d = rt_val;
                    state_d = S_MEM;
                end else begin
                    illegal_d = illegal_c;
                    state_d   = S_WB;
                end
            end
            S_MEM: begin
                if (!DBUSYWAIT) begin
                    if (read_q) res_d = READDATA;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                rf_we   = wen_q;
                pc_d    = npc_q;
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            npc_q     <= '0;
            ir_q      <= '0;
            res_q     <= '0;
            wen_q     <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            npc_q     <= npc_d;
            ir_q      <= ir_d;
            res_q     <= res_d;
            wen_q     <= wen_d;
            read_q    <= read_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            illegal_q <= illegal_d;
        end
    end

    // Register file: single write port used only in WB
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
        end else if (rf_we) begin
            regs_q[rd_idx] <= res_q;
        end
    end

    assign PC        = pc_q;
    assign READ      = read_q;
    assign WRITE     = write_q;
    assign ADDRESS   = addr_q;
    assign WRITEDATA = wdata_q;
    assign ILLEGAL   = illegal_q;

endmodule

// File: tb/tb_cpu_mc.sv
// tb_cpu_mc: random program against an instruction-level reference model; scoreboard checks PC, memory traffic and ILLEGAL.
`timescale 1ns/1ps
module tb_cpu_mc;
    localparam int DW    = 8;
    localparam int NIW   = 1024;
    localparam int NPRE  = 24;
    localparam int NRAND = 160;
    localparam longint MASK = (longint'(1) << DW) - 1;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [31:0]   PC;
    logic [31:0]   INSTRUCTION;
    logic          IBUSYWAIT;
    logic          READ, WRITE;
    logic [DW-1:0] ADDRESS, WRITEDATA, READDATA;
    logic          DBUSYWAIT;
    logic          ILLEGAL;

    cpu_mc dut (
        .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION), .IBUSYWAIT(IBUSYWAIT),
        .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA),
        .READDATA(READDATA), .DBUSYWAIT(DBUSYWAIT), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] npc;
        int kind;      // 0 none, 1 read, 2 write
        int addr;
        int data;
        int ill;
    } exp_t;

    exp_t        exp_q[$];
    int          acc_q[$];
    logic [31:0] imem [NIW];
    bit          imem_set [NIW];
    logic [7:0]  dmem [256];
    longint      mdm [256];
    longint      R [8];
    longint      mpc;
    longint      exp_w40;
    int          n_cmp, n_fail;
    bit          run, done, hold_busy;

    logic [31:0] pre [NPRE] = '{
        32'h00_02_00_05, 32'h00_03_00_07, 32'h03_04_02_03, 32'h02_05_04_03,
        32'h06_01_00_00, 32'h06_01_00_00, 32'h07_FE_02_02, 32'h0C_05_02_02,
        32'h0A_00_04_05, 32'h09_01_00_20, 32'h00_02_00_10, 32'h0A_00_01_02,
        32'h00_06_00_80, 32'h10_07_06_09, 32'h0F_00_06_09, 32'h00_01_00_10,
        32'h00_02_00_11, 32'h0D_03_01_02, 32'h3F_00_00_00, 32'h0B_00_04_30,
        32'h0B_00_05_31, 32'h0B_00_07_32, 32'h0B_00_00_33, 32'h0B_00_03_34
    };

    task automatic chk(input string nm, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] gen_rand();
        int sel;
        logic [7:0] op, f2, f1, f0;
        sel = int'($urandom_range(0, 19));
        if (sel <= 16) op = 8'(sel);
        else           op = 8'($urandom_range(17, 255));
        f2 = 8'($urandom_range(0, 255));
        f1 = 8'($urandom_range(0, 255));
        f0 = 8'($urandom_range(0, 255));
        if (op == 8'h06 || op == 8'h07 || op == 8'h0C) f2 = 8'($urandom_range(0, 3));
        if (op >= 8'h0E && op <= 8'h10) f0 = 8'($urandom_range(0, 12));
        return {op, f2, f1, f0};
    endfunction

    // Instruction-set model: one architectural instruction per call
    task automatic model_step();
        logic [31:0] ir;
        exp_t   e;
        int     op, rd, rt, rs, imm, off;
        longint a, b, sa, res, npc, soff;
        bit     wr;
        ir  = imem[int'(mpc[11:2])];
        op  = int'(ir[31:24]);
        rd  = int'(ir[18:16]);
        rt  = int'(ir[10:8]);
        rs  = int'(ir[2:0]);
        imm = int'(ir[7:0]);
        off = int'(ir[23:16]);
        soff = (off >= 128) ? longint'(off - 256) : longint'(off);
        a = R[rt];
        b = R[rs];
        e.kind = 0; e.addr = 0; e.data = 0; e.ill = 0;
        wr = 0; res = 0;
        npc = mpc + 4;
        case (op)
            0:  begin res = (imm >= 128) ? longint'(imm - 256) : longint'(imm); wr = 1; end
            1:  begin res = b;     wr = 1; end
            2:  begin res = a + b; wr = 1; end
            3:  begin res = a - b; wr = 1; end
            4:  begin res = a & b; wr = 1; end
            5:  begin res = a | b; wr = 1; end
            6:  npc = mpc + 4 + soff * 4;
            7:  if (a == b) npc = mpc + 4 + soff * 4;
            12: if (a != b) npc = mpc + 4 + soff * 4;
            8:  begin e.kind = 1; e.addr = int'(b);   res = mdm[int'(b)];   wr = 1; end
            9:  begin e.kind = 1; e.addr = imm;       res = mdm[imm];       wr = 1; end
            10: begin e.kind = 2; e.addr = int'(b); e.data = int'(a); mdm[int'(b)] = a; end
            11: begin e.kind = 2; e.addr = imm;     e.data = int'(a); mdm[imm] = a; end
`ifdef CPU_MC_MULT_EN
            13: begin res = a * b; wr = 1; end
`endif
            14: begin res = (imm >= DW) ? 0 : (a << imm); wr = 1; end
            15: begin res = (imm >= DW) ? 0 : (a >> imm); wr = 1; end
            16: begin
                sa  = (a >= (longint'(1) << (DW - 1))) ? a - (longint'(1) << DW) : a;
                res = (imm >= DW) ? ((sa < 0) ? MASK : 0) : (sa >>> imm);
                wr  = 1;
            end
            default: e.ill = 1;
        endcase
        if (wr) R[rd] = res & MASK;
        npc   = npc & 64'hFFFF_FFFF;
        e.npc = 32'(npc);
        exp_q.push_back(e);
        mpc = npc;
    endtask

    // Memory models: random fetch and data stalls, garbage on buses while stalled
    logic [31:0] drv_pc;
    int          ib_cnt, d_cnt;
    bit          d_in;

    always @(negedge CLK) begin
        if (!run) begin
            IBUSYWAIT   = 1'b1;
            DBUSYWAIT   = 1'b0;
            INSTRUCTION = $urandom;
            READDATA    = 8'($urandom);
            d_in        = 1'b0;
        end else begin
            if (PC != drv_pc) begin
                drv_pc = PC;
                ib_cnt = int'($urandom_range(0, 2));
            end
            if (ib_cnt > 0) begin
                IBUSYWAIT   = 1'b1;
                INSTRUCTION = $urandom;
                ib_cnt--;
            end else begin
                IBUSYWAIT   = 1'b0;
                INSTRUCTION = imem[PC[11:2]];
            end
            if (READ || WRITE) begin
                if (!d_in) begin
                    d_in  = 1'b1;
                    d_cnt = int'($urandom_range(0, 3));
                    acc_q.push_back(d_cnt + 1);
                end
                if (hold_busy || d_cnt > 0) begin
                    DBUSYWAIT = 1'b1;
                    READDATA  = 8'($urandom);
                    if (d_cnt > 0) d_cnt--;
                end else begin
                    DBUSYWAIT = 1'b0;
                    READDATA  = dmem[ADDRESS];
                    if (WRITE) dmem[ADDRESS] = WRITEDATA;
                    d_in = 1'b0;
                end
            end else begin
                DBUSYWAIT = 1'b0;
                READDATA  = 8'($urandom);
                d_in      = 1'b0;
            end
        end
    end

    // Monitor: gathers per-instruction activity and retires one expectation per PC update
    logic [31:0] m_pc;
    int          m_kind, m_addr, m_data, m_ill, m_cyc;
    exp_t        m_e;

    always begin
        @(negedge CLK);
        #2;
        if (run && !done) begin
            if (ILLEGAL) m_ill++;
            if (READ || WRITE) begin
                m_cyc++;
                if (!DBUSYWAIT) begin
                    m_kind = (READ && WRITE) ? 3 : (READ ? 1 : 2);
                    m_addr = int'(ADDRESS);
                    m_data = int'(WRITEDATA);
                    if (acc_q.size() > 0) chk("mem_cycles", m_cyc, acc_q.pop_front());
                    else                  chk("mem_cycles_unexpected", m_cyc, 0);
                    m_cyc = 0;
                end
            end
            if (PC != m_pc) begin
                if (exp_q.size() == 0) begin
                    chk("extra_instr", 1, 0);
                    done = 1'b1;
                end else begin
                    m_e = exp_q.pop_front();
                    chk("pc", PC, m_e.npc);
                    chk("mem_kind", m_kind, m_e.kind);
                    if (m_e.kind != 0) chk("mem_addr", m_addr, m_e.addr);
                    if (m_e.kind == 2) chk("mem_wdata", m_data, m_e.data);
                    chk("illegal_cycles", m_ill, m_e.ill);
                    if (exp_q.size() == 0) begin
                        done      = 1'b1;
                        hold_busy = 1'b1;
                    end
                end
                m_kind = 0;
                m_ill  = 0;
                m_pc   = PC;
            end
        end
    end

    initial begin
        int c2;
        n_cmp = 0; n_fail = 0;
        run = 0; done = 0; hold_busy = 0;
        RESET = 1'b0;
        drv_pc = '1; ib_cnt = 0; d_cnt = 0;
        m_pc = '0; m_kind = 0; m_addr = 0; m_data = 0; m_ill = 0; m_cyc = 0;

        for (int i = 0; i < 256; i++) begin
            dmem[i] = 8'($urandom);
            mdm[i]  = longint'(dmem[i]);
        end
        dmem[8'h20] = 8'hA5;
        mdm[8'h20]  = 64'hA5;
        for (int i = 0; i < NIW; i++) begin
            imem[i] = '0;
            imem_set[i] = 1'b0;
        end
        for (int i = 0; i < NPRE; i++) begin
            imem[i] = pre[i];
            imem_set[i] = 1'b1;
        end
        for (int i = 0; i < 8; i++) R[i] = 0;
        mpc = 0;
        while (mpc < 4 * NPRE) model_step();
        for (int k = 0; k < NRAND; k++) begin
            if (!imem_set[int'(mpc[11:2])]) begin
                imem[int'(mpc[11:2])] = gen_rand();
                imem_set[int'(mpc[11:2])] = 1'b1;
            end
            model_step();
        end
        for (int r = 0; r < 8; r++) begin
            imem[int'(mpc[11:2])] = {8'h0B, 8'h00, 8'(r), 8'(8'hE0 + r)};
            model_step();
        end
        imem[int'(mpc[11:2])] = {8'h0B, 8'h00, 8'h01, 8'h40};
        exp_w40 = R[1];

        repeat (2) @(negedge CLK);
        #2;
        chk("rst_pc", PC, 0);
        chk("rst_read", READ, 0);
        chk("rst_write", WRITE, 0);
        chk("rst_address", ADDRESS, 0);
        chk("rst_writedata", WRITEDATA, 0);
        chk("rst_illegal", ILLEGAL, 0);

        @(negedge CLK);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        #2;
        chk("fetch_stall_pc", PC, 0);
        chk("fetch_stall_read", READ, 0);
        #1 RESET = 1'b0;
        #1;
        chk("midfetch_rst_pc", PC, 0);
        chk("midfetch_rst_write", WRITE, 0);

        @(negedge CLK);
        RESET = 1'b1;
        run   = 1'b1;

        for (int c = 0; c < 30000 && !done; c++) @(negedge CLK);
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: %0d instructions still expected", exp_q.size());
        end else begin
            c2 = 0;
            while (!WRITE && c2 < 100) begin
                @(negedge CLK);
                c2++;
            end
            #2;
            chk("p2_write", WRITE, 1);
            chk("p2_address", ADDRESS, 64'h40);
            chk("p2_writedata", WRITEDATA, exp_w40);
            @(negedge CLK);
            #2;
            chk("p2_write_held", WRITE, 1);
            #1 RESET = 1'b0;
            #1;
            chk("midaccess_rst_write", WRITE, 0);
            chk("midaccess_rst_read", READ, 0);
            chk("midaccess_rst_pc", PC, 0);
            chk("midaccess_rst_address", ADDRESS, 0);
            chk("midaccess_rst_writedata", WRITEDATA, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
